// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port block-RAM arbiter.
package ram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port block RAM: round-robin on ties,
// lockable bursts capped at MAX_BURST accesses, one-cycle read return.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_ARB  | no owner; round-robin between requesters, rr_last loses ties
// ST_OWN0 | requester 0 holds a locked burst; requester 1 stalls
// ST_OWN1 | requester 1 holds a locked burst; requester 0 stalls
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RAM_ADDR_BITS = 8,
    parameter int RAM_WIDTH     = 8,
    parameter int MAX_BURST     = 16
) (
    input  logic                     clk,
    input  logic                     rst_sync,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [NUM_REQ-1:0]       we,
    input  logic [RAM_ADDR_BITS-1:0] addr0,
    input  logic [RAM_ADDR_BITS-1:0] addr1,
    input  logic [RAM_WIDTH-1:0]     wdata0,
    input  logic [RAM_WIDTH-1:0]     wdata1,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rvalid,
    output logic [RAM_WIDTH-1:0]     rdata,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]     ram_wdata,
    input  logic [RAM_WIDTH-1:0]     ram_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1) + 2;

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic               r_rr_last;
    logic               w_rr_last_nxt;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [CNT_W-1:0]   w_burst_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [NUM_REQ-1:0] r_rvalid;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_acc;
    logic               w_sel;

    always_comb begin
        w_gnt = '0;
        if (!rst_sync) begin
            case (r_state)
                ST_OWN0: w_gnt[0] = req[0];
                ST_OWN1: w_gnt[1] = req[1];
                default: begin
                    w_gnt[0] = req[0] & (~req[1] | r_rr_last);
                    w_gnt[1] = req[1] & (~req[0] | ~r_rr_last);
                end
            endcase
        end
    end

    assign w_acc     = |w_gnt;
    assign w_sel     = w_gnt[1];
    // An access taken from ST_ARB is the first of a new burst.
    assign w_cnt_inc = ((r_state == ST_ARB) ? '0 : r_burst_cnt) + CNT_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        w_rr_last_nxt   = r_rr_last;
        if (w_acc) begin
            w_rr_last_nxt = w_sel;
            if (lock[w_sel] && (w_cnt_inc < CNT_W'(MAX_BURST))) begin
                w_state_nxt     = w_sel ? ST_OWN1 : ST_OWN0;
                w_burst_cnt_nxt = w_cnt_inc;
            end else begin
                w_state_nxt     = ST_ARB;
                w_burst_cnt_nxt = '0;
            end
        end else if ((r_state == ST_OWN0 && !req[0] && !lock[0]) ||
                     (r_state == ST_OWN1 && !req[1] && !lock[1])) begin
            w_state_nxt     = ST_ARB;
            w_burst_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_state     <= ST_ARB;
            r_rr_last   <= 1'b1;
            r_burst_cnt <= '0;
            r_rvalid    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_last   <= w_rr_last_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_rvalid    <= w_gnt & ~we;
        end
    end

    assign gnt       = w_gnt;
    // A read accepted just before reset must not surface while reset is held.
    assign rvalid    = r_rvalid & {NUM_REQ{~rst_sync}};
    assign rdata     = ram_rdata;
    assign ram_en    = w_acc;
    assign ram_we    = w_acc & we[w_sel];
    assign ram_addr  = w_sel ? addr1 : addr0;
    assign ram_wdata = w_sel ? wdata1 : wdata0;

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter RAM_ADDR_BITS, default 8, block-RAM address width.
REQ-002 Parameter RAM_WIDTH, default 8, block-RAM data width.
REQ-003 Parameter MAX_BURST, default 16, max consecutive locked accesses by one requester (range 1..255).
REQ-004 clk  input  1  single system clock; all logic is on the rising edge.
REQ-005 rst_sync  input  1  synchronous, active-high reset.
REQ-006 req[1:0]  input  2  per-requester access request; index 0 = UART command engine, index 1 = local requester.
REQ-007 lock[1:0]  input  2  per-requester burst hold; sampled with an accepted access.
REQ-008 we[1:0]  input  2  per-requester write enable; 0 = read.
REQ-009 addr0, addr1  input  RAM_ADDR_BITS each  per-requester address.
REQ-010 wdata0, wdata1  input  RAM_WIDTH each  per-requester write data.
REQ-011 gnt[1:0]  output  2  grant; an access is accepted in any cycle where req[i] and gnt[i] are both high.
REQ-012 rvalid[1:0]  output  2  read-data valid strobe, one per requester.
REQ-013 rdata  output  RAM_WIDTH  read data, shared by both requesters and qualified by rvalid.
REQ-014 ram_en, ram_we  output  1 each  RAM port enable and write enable.
REQ-015 ram_addr, ram_wdata  output  RAM_ADDR_BITS / RAM_WIDTH  RAM port address and write data.
REQ-016 ram_rdata  input  RAM_WIDTH  RAM read data, valid one cycle after ram_en with ram_we low.

Function
REQ-017 gnt shall be combinational from registered state and req, and shall be one-hot or zero; at most one access reaches the RAM per cycle.
REQ-018 The FSM shall have states ARB (no owner) and OWN0/OWN1 (burst owner).
REQ-019 In ARB, a single requester shall be granted; if both request, the requester not served last (rr_last) shall be granted.
REQ-020 An accepted access with lock high shall move or keep the FSM in OWNi; with lock low the FSM shall return to ARB.
REQ-021 In OWNi, gnt shall be given only to requester i; the other requester shall stall even if requester i drops req.
REQ-022 A 2-bit-wider burst counter shall count accepted accesses in OWNi.
REQ-023 On the MAX_BURST-th access the FSM shall return to ARB regardless of lock, and rr_last=i shall give the other requester priority.
REQ-024 In OWNi, when req[i] is low and lock was released, the FSM shall exit to ARB; a locked owner idling shall keep ownership, with no timeout.
REQ-025 rr_last shall update to i on every accepted access by requester i.
REQ-026 ram_en/ram_we/ram_addr/ram_wdata shall combinationally mirror the accepted requester; when no access is accepted, ram_en=0 and ram_we=0.
REQ-027 For a read accepted in cycle N, rvalid[i] shall be high in cycle N+1 with rdata=ram_rdata.
REQ-028 Writes shall produce no rvalid.
REQ-029 Back-to-back reads shall give one rvalid per cycle with no bubble.

Reset
REQ-030 While rst_sync is high: FSM=ARB, rr_last=1 (requester 0 wins first tie), burst counter=0, rvalid=0, and gnt=0 regardless of req.
REQ-031 Reset mid-burst shall drop ownership, and an in-flight rvalid shall be suppressed in the cycle after reset.

Structure
REQ-032 Package ram_arb_pkg shall hold the FSM state enum and the NUM_REQ=2 constant.
REQ-033 The block shall be one module with no sub-module; the RAM itself stays outside.

Verification
REQ-034 Both read in the same cycle after reset at addr0=0x10, addr1=0x20: gnt=01, then gnt=10; rvalid[0] at N+1 and rvalid[1] at N+2 with the RAM contents.
REQ-035 Requester 1 holds lock for 20 writes with MAX_BURST=16 while req[0] is high: 16 writes by requester 1, then one grant to requester 0, then requester 1 resumes.
REQ-036 Locked owner 0 drops req for 3 cycles while req[1] is high: gnt stays 00 for those cycles, and no RAM access occurs.
REQ-037 Write 0xA5 to addr 0x05 by requester 1, then read 0x05 by requester 0: rdata=0xA5 with rvalid=01, and rvalid[1] never pulses.
REQ-038 rst_sync pulsed during OWN1 with a read in flight: next cycle rvalid=00, FSM=ARB, and a tie then grants requester 0.
